vga_text_gen: RTL and testbench

- Parametrised VGA text-mode generator; successor to the fixed-resolution vga_char block.
- Produces sync timing from sys_clk through a pixel-enable divider and holds a COLS x ROWS character buffer written through a simple port.
- Each cell is an 8x16 glyph with per-cell foreground/background colour, read from an external font ROM.
- Sits between the system bus or CPU writer and the board VGA DAC pins.

---
 rtl/vga_text_gen.sv | 226 ++++++++++++++++++++++
 tb/tb_vga_text_gen.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/vga_text_gen.sv
// VGA text-mode generator: sync timing, COLS x ROWS character RAM, 8x16 glyphs from an external font ROM.
// Define VGA_TEXT_CURSOR_EN to add a blinking underline cursor at cursor_addr.
module vga_text_gen #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter int   CLK_DIV  = 2,
    parameter int   COLS     = 80,
    parameter int   ROWS     = 30,
    parameter int   COLOR_W  = 4,
    parameter logic SYNC_POL = 1'b0,
    localparam int  AW       = $clog2(COLS * ROWS)
) (
    input  logic               sys_clk,
    input  logic               rst_n,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_addr,
    input  logic [15:0]        wr_data,
`ifdef VGA_TEXT_CURSOR_EN
    input  logic [AW-1:0]      cursor_addr,
`endif
    output logic [11:0]        font_addr,
    input  logic [7:0]         font_data,
    output logic               hsync,
    output logic               vsync,
    output logic [COLOR_W-1:0] vga_r,
    output logic [COLOR_W-1:0] vga_g,
    output logic [COLOR_W-1:0] vga_b,
    output logic               de,
    output logic               frame_start
);

    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW    = $clog2(H_TOT);
    localparam int VW    = $clog2(V_TOT);
    localparam int CELLS = COLS * ROWS;
    localparam int DW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [HW-1:0] H_LAST   = HW'(H_TOT - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOT - 1);

    // A channel is all-ones when its colour bit is set inside active video, else zero.
    function automatic logic [COLOR_W-1:0] chan_level(input logic vis, input logic bit_v);
        return {COLOR_W{vis & bit_v}};
    endfunction

    function automatic logic pix_select(input logic [7:0] row_bits, input logic [2:0] x,
                                        input logic force_fg);
        return force_fg | row_bits[3'd7 - x];
    endfunction

    logic [DW-1:0] div_cnt;
    logic          pe;
    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          active;
    logic          hs_raw;
    logic          vs_raw;
    logic          fs_raw;
    logic [AW-1:0] rd_addr;
    logic          cur_hit;

    assign pe = (div_cnt == DIV_LAST);

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (pe) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DW'(1);
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pe) begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
            end else begin
                h_cnt <= h_cnt + HW'(1);
            end
        end
    end

    assign active  = (32'(h_cnt) < H_ACTIVE) && (32'(v_cnt) < V_ACTIVE);
    assign hs_raw  = (32'(h_cnt) >= H_ACTIVE + H_FP) && (32'(h_cnt) < H_ACTIVE + H_FP + H_SYNC);
    assign vs_raw  = (32'(v_cnt) >= V_ACTIVE + V_FP) && (32'(v_cnt) < V_ACTIVE + V_FP + V_SYNC);
    assign fs_raw  = (h_cnt == '0) && (v_cnt == '0);
    assign rd_addr = AW'(32'(v_cnt >> 4) * COLS + 32'(h_cnt >> 3));

`ifdef VGA_TEXT_CURSOR_EN
    logic [4:0] blink_cnt;

    // Counts completed frames; the top bit gives 16 frames on, 16 frames off.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt <= '0;
        end else if (pe && (h_cnt == H_LAST) && (v_cnt == V_LAST)) begin
            blink_cnt <= blink_cnt + 5'd1;
        end
    end

    assign cur_hit = !blink_cnt[4] && (32'(cursor_addr) < CELLS) &&
                     (rd_addr == cursor_addr) && (v_cnt[3:1] == 3'b111);
`else
    assign cur_hit = 1'b0;
`endif

    logic [15:0] mem [CELLS];

    always_ff @(posedge sys_clk) begin
        if (wr_en && (32'(wr_addr) < CELLS)) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // S1: character RAM read and counter-derived flags
    logic [15:0] cell_p0;
    logic [2:0]  x_p0;
    logic [3:0]  y_p0;
    logic        vld_p0, hs_p0, vs_p0, fs_p0, cur_p0;

    always_ff @(posedge sys_clk) begin
        if (pe && active) begin
            cell_p0 <= mem[rd_addr];
        end
    end

    always_ff @(posedge sys_clk) begin
        if (pe) begin
            x_p0 <= h_cnt[2:0];
            y_p0 <= v_cnt[3:0];
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0 <= 1'b0;
            hs_p0  <= 1'b0;
            vs_p0  <= 1'b0;
            fs_p0  <= 1'b0;
            cur_p0 <= 1'b0;
        end else if (pe) begin
            vld_p0 <= active;
            hs_p0  <= hs_raw;
            vs_p0  <= vs_raw;
            fs_p0  <= fs_raw;
            cur_p0 <= cur_hit;
        end
    end

    // S2: font ROM lookup and attribute capture
    logic [7:0] font_p1;
    logic [2:0] fg_p1, bg_p1, x_p1;
    logic       vld_p1, hs_p1, vs_p1, fs_p1, cur_p1;
    logic       unused_reserved;

    assign font_addr       = {cell_p0[7:0], y_p0};
    assign unused_reserved = &{1'b0, cell_p0[15], cell_p0[11]};

    always_ff @(posedge sys_clk) begin
        if (pe) begin
            font_p1 <= font_data;
            fg_p1   <= cell_p0[10:8];
            bg_p1   <= cell_p0[14:12];
            x_p1    <= x_p0;
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
            hs_p1  <= 1'b0;
            vs_p1  <= 1'b0;
            fs_p1  <= 1'b0;
            cur_p1 <= 1'b0;
        end else if (pe) begin
            vld_p1 <= vld_p0;
            hs_p1  <= hs_p0;
            vs_p1  <= vs_p0;
            fs_p1  <= fs_p0;
            cur_p1 <= cur_p0;
        end
    end

    // S3: output register; frame_start is gated by pe so it lasts a single sys_clk
    logic       pix_on;
    logic [2:0] col_sel;

    assign pix_on  = pix_select(font_p1, x_p1, cur_p1);
    assign col_sel = pix_on ? fg_p1 : bg_p1;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            vga_r       <= '0;
            vga_g       <= '0;
            vga_b       <= '0;
            de          <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= pe && fs_p1;
            if (pe) begin
                hsync <= hs_p1 ? SYNC_POL : ~SYNC_POL;
                vsync <= vs_p1 ? SYNC_POL : ~SYNC_POL;
                de    <= vld_p1;
                vga_r <= chan_level(vld_p1, col_sel[2]);
                vga_g <= chan_level(vld_p1, col_sel[1]);
                vga_b <= chan_level(vld_p1, col_sel[0]);
            end
        end
    end

endmodule

// File: tb/tb_vga_text_gen.sv
// Directed bench for vga_text_gen on a reduced 40x52 raster (4x3 cells), CLK_DIV=2.
module tb_vga_text_gen;

    localparam int AW = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic [11:0] font_addr;
    logic [7:0]  font_data;
    logic        hsync, vsync, de, frame_start;
    logic [3:0]  vga_r, vga_g, vga_b;

    int cyc = 0;
    int total = 0;
    int bad = 0;

    vga_text_gen #(
        .H_ACTIVE(32), .H_FP(2), .H_SYNC(4), .H_BP(2),
        .V_ACTIVE(48), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .CLK_DIV(2), .COLS(4), .ROWS(3), .COLOR_W(4), .SYNC_POL(1'b0)
    ) dut (
        .sys_clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .font_addr(font_addr), .font_data(font_data), .hsync(hsync), .vsync(vsync),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .de(de), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    // sys_clk edges since the last reset release
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // Font ROM: 'A' row 0 has only the leftmost pixel; char 0x55 alternates on every row.
    always_comb begin
        font_data = 8'h00;
        if (font_addr == 12'h410) font_data = 8'h80;
        else if (font_addr[11:4] == 8'h55) font_data = 8'hAA;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        int guard;
        guard = 0;
        while (cyc < n && guard < 20000) begin
            @(negedge clk);
            guard++;
        end
        if (cyc != n) begin
            bad++;
            $display("FAIL wait_cyc observed=%0d expected=%0d", cyc, n);
        end
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [15:0] d);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_hs"}, hsync, 1'b1);
        chk({tag, "_vs"}, vsync, 1'b1);
        chk({tag, "_rgb"}, {vga_r, vga_g, vga_b}, 12'h000);
        chk({tag, "_de"}, de, 1'b0);
        chk({tag, "_fs"}, frame_start, 1'b0);
    endtask

    initial begin
        wr(4'd0,  16'h1741);
        wr(4'd5,  16'h0255);
        wr(4'd11, 16'h7020);
        wr(4'd12, 16'h0700);
        @(negedge clk);
        @(negedge clk);
        chk_reset_vals("rst");
        rst_n = 1'b1;

        wait_cyc(2);    chk("font_addr00", font_addr, 12'h410);
        wait_cyc(6);    chk("pix00_rgb", {vga_r, vga_g, vga_b}, 12'hFFF);
                        chk("pix00_de", de, 1'b1);
                        chk("pix00_fs", frame_start, 1'b1);
        wait_cyc(7);    chk("fs_one_clk", frame_start, 1'b0);
        wait_cyc(8);    chk("pix10_rgb", {vga_r, vga_g, vga_b}, 12'h00F);
        wait_cyc(72);   chk("hfp_de", de, 1'b0);
                        chk("hfp_rgb", {vga_r, vga_g, vga_b}, 12'h000);
                        chk("hfp_hs", hsync, 1'b1);
        wait_cyc(74);   chk("hs_start", hsync, 1'b0);
        wait_cyc(80);   chk("hs_last", hsync, 1'b0);
        wait_cyc(82);   chk("hs_end", hsync, 1'b1);
        wait_cyc(1622); chk("c5_x0_rgb", {vga_r, vga_g, vga_b}, 12'h0F0);
        wait_cyc(1624); chk("c5_x1_rgb", {vga_r, vga_g, vga_b}, 12'h000);
        wait_cyc(3256); chk("c11_bg_rgb", {vga_r, vga_g, vga_b}, 12'hFFF);
                        chk("c11_de", de, 1'b1);
        wait_cyc(3846); chk("vfp_de", de, 1'b0);
                        chk("vfp_vs", vsync, 1'b1);
        wait_cyc(3926); chk("vs_start", vsync, 1'b0);
        wait_cyc(4086); chk("vs_end", vsync, 1'b1);

        // Rewrite cell 0 on the very edge that S1 reads it for frame 1 (h=0,v=0).
        wait_cyc(4161);
        wr_en = 1'b1; wr_addr = 4'd0; wr_data = 16'h0441;
        wait_cyc(4162);
        wr_en = 1'b0;
        wait_cyc(4166); chk("f1_pix00_old", {vga_r, vga_g, vga_b}, 12'hFFF);
                        chk("f1_fs", frame_start, 1'b1);
        wait_cyc(8326); chk("f2_pix00_new", {vga_r, vga_g, vga_b}, 12'hF00);
                        chk("f2_fs", frame_start, 1'b1);

        // Reset in the middle of line 20 of frame 2.
        wait_cyc(9942); chk("pre_rst_rgb", {vga_r, vga_g, vga_b}, 12'h0F0);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("mid_rst");
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wait_cyc(5);    chk("rel_fs_early", frame_start, 1'b0);
                        chk("rel_de_early", de, 1'b0);
        wait_cyc(6);    chk("rel_fs", frame_start, 1'b1);
                        chk("rel_pix00", {vga_r, vga_g, vga_b}, 12'hF00);
                        chk("rel_de", de, 1'b1);
        wait_cyc(1622); chk("rel_line20", {vga_r, vga_g, vga_b}, 12'h0F0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
